// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions and
// the control FSM state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_NOT   = 4'd3,
    OP_ADD   = 4'd4,
    OP_ADDU  = 4'd5,
    OP_ADDC  = 4'd6,
    OP_ADDCU = 4'd7,
    OP_SUB   = 4'd8,
    OP_CMP   = 4'd9,
    OP_CMPU  = 4'd10,
    OP_MOV   = 4'd11,
    OP_LSH   = 4'd12,
    OP_ASH   = 4'd13
  } op_e;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic op_is_shift(input logic [3:0] code);
    return (code == OP_LSH) || (code == OP_ASH);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter. Loads on start, shifts while the
// counter is non-zero and raises done once the counter has drained.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             left,
  input  logic             arith,
  input  logic [SHW:0]     amount,
  input  logic [WIDTH-1:0] din,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             last_out
);

  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  logic             active;
  logic [SHW:0]     cnt;
  logic             left_q;
  logic             arith_q;
  logic             last_q;
  logic [WIDTH-1:0] data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= amount;
    end else if (active) begin
      if (cnt == '0) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Arithmetic right shifts replicate the sign bit; left shifts always fill zero.
  always_ff @(posedge clk) begin
    if (start) begin
      data    <= din;
      left_q  <= left;
      arith_q <= arith;
      last_q  <= 1'b0;
    end else if (active && (cnt != '0)) begin
      if (left_q) begin
        last_q <= data[WIDTH-1];
        data   <= {data[WIDTH-2:0], 1'b0};
      end else begin
        last_q <= data[0];
        data   <= {arith_q & data[WIDTH-1], data[WIDTH-1:1]};
      end
    end
  end

  assign done     = active && (cnt == '0);
  assign dout     = data;
  assign last_out = last_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input, internal ZCFNL flag register and an
// iterative shifter for non-zero shift amounts.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_result_we,
  output logic [4:0]       flags
);

  localparam logic [SHW:0] AMT_ONE = {{SHW{1'b0}}, 1'b1};

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  state_e state, state_nxt;

  logic             accept;
  logic             shift_start;
  logic             shift_done;
  logic             shift_emit;
  logic [SHW:0]     b_amt;
  logic [SHW:0]     sh_mag;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_last;
  logic [4:0]       sh_flags;

  // Shift amount is two's complement in B[SHW:0]; the sign picks the direction.
  assign b_amt       = b[SHW:0];
  assign sh_mag      = b_amt[SHW] ? (~b_amt + AMT_ONE) : b_amt;
  assign in_ready    = (state == IDLE) || shift_done;
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && op_is_shift(op) && (b_amt != '0);
  assign shift_emit  = (state == SHIFT) && shift_done;

  alu_shift_unit #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (shift_start),
    .left    (~b_amt[SHW]),
    .arith   (op == OP_ASH),
    .amount  (sh_mag),
    .din     (a),
    .done    (shift_done),
    .dout    (sh_dout),
    .last_out(sh_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_start) state_nxt = SHIFT;
      SHIFT:   if (shift_done) state_nxt = shift_start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: capture accepted single-cycle operation ----
  logic             vld_p0;
  logic [3:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept && !shift_start;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= op;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  // ---- stage p1: evaluate op against the live flag register ----
  logic signed [WIDTH-1:0] a_s_p0;
  logic signed [WIDTH-1:0] b_s_p0;
  logic                    carry_in;
  logic [WIDTH:0]          sum_p0;
  logic [WIDTH:0]          diff_p0;
  logic [WIDTH-1:0]        res_p1;
  logic [4:0]              flags_p1;
  logic                    we_p1;
  logic                    upd_p1;
  logic                    cmp_op;

  assign a_s_p0   = a_p0;
  assign b_s_p0   = b_p0;
  assign carry_in = ((op_p0 == OP_ADDC) || (op_p0 == OP_ADDCU)) && flags[FLAG_C];
  assign sum_p0   = {1'b0, a_p0} + {1'b0, b_p0} + {{WIDTH{1'b0}}, carry_in};
  assign diff_p0  = {1'b0, a_p0} - {1'b0, b_p0};
  assign cmp_op   = (op_p0 == OP_CMP) || (op_p0 == OP_CMPU);

  always_comb begin
    res_p1   = a_p0;
    flags_p1 = '0;
    we_p1    = 1'b1;
    upd_p1   = 1'b1;
    case (op_p0)
      OP_AND:  res_p1 = a_p0 & b_p0;
      OP_OR:   res_p1 = a_p0 | b_p0;
      OP_XOR:  res_p1 = a_p0 ^ b_p0;
      OP_NOT:  res_p1 = ~a_p0;
      OP_ADD: begin
        res_p1           = sum_p0[WIDTH-1:0];
        flags_p1[FLAG_F] = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
      end
      OP_ADDU: begin
        res_p1           = sum_p0[WIDTH-1:0];
        flags_p1[FLAG_C] = sum_p0[WIDTH];
      end
      OP_ADDC: begin
        res_p1           = sum_p0[WIDTH-1:0];
        flags_p1[FLAG_F] = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
        flags_p1[FLAG_C] = sum_p0[WIDTH];
      end
      OP_ADDCU: begin
        res_p1           = sum_p0[WIDTH-1:0];
        flags_p1[FLAG_C] = sum_p0[WIDTH];
      end
      OP_SUB: begin
        res_p1           = diff_p0[WIDTH-1:0];
        flags_p1[FLAG_F] = sub_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], diff_p0[WIDTH-1]);
        flags_p1[FLAG_C] = diff_p0[WIDTH];
      end
      OP_CMP, OP_CMPU: begin
        res_p1           = '0;
        we_p1            = 1'b0;
        flags_p1[FLAG_N] = a_s_p0 < b_s_p0;
        flags_p1[FLAG_L] = a_p0 < b_p0;
      end
      OP_MOV:         res_p1 = b_p0;
      OP_LSH, OP_ASH: res_p1 = a_p0;
      default: begin
        we_p1  = 1'b0;
        upd_p1 = 1'b0;
      end
    endcase
    flags_p1[FLAG_Z] = cmp_op ? (a_p0 == b_p0) : (res_p1 == '0);
  end

  always_comb begin
    sh_flags         = '0;
    sh_flags[FLAG_Z] = (sh_dout == '0);
    sh_flags[FLAG_C] = sh_last;
  end

  // ---- output register: single-cycle result or finished shift ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_result_we <= 1'b0;
      out_result    <= '0;
      flags         <= '0;
    end else begin
      out_valid     <= 1'b0;
      out_result_we <= 1'b0;
      if (shift_emit) begin
        out_valid     <= 1'b1;
        out_result_we <= 1'b1;
        out_result    <= sh_dout;
        flags         <= sh_flags;
      end else if (vld_p0) begin
        out_valid     <= 1'b1;
        out_result_we <= we_p1;
        if (upd_p1) begin
          out_result <= res_p1;
          flags      <= flags_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: a 16-bit instance driven through a
// reference model, plus a 32-bit instance for the wide-datapath cases.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        we;
    logic [4:0]  fl;
    int          cyc;
    string       tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] out_result;
  logic        out_result_we;
  logic [4:0]  flags;

  logic        in_valid32;
  logic        in_ready32;
  logic [3:0]  op32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        out_valid32;
  logic [31:0] out_result32;
  logic        out_result_we32;
  logic [4:0]  flags32;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] m_res;
  logic [4:0]  m_flags;
  sb_t         q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_result_we(out_result_we),
    .flags        (flags)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid32),
    .in_ready     (in_ready32),
    .op           (op32),
    .a            (a32),
    .b            (b32),
    .out_valid    (out_valid32),
    .out_result   (out_result32),
    .out_result_we(out_result_we32),
    .flags        (flags32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns expected result/we/flags/latency and advances model state.
  task automatic predict(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic we, output logic [4:0] fl,
                         output int lat);
    int ux, uy, sx, sy, ci, t, s, mag;
    logic [15:0] v;
    logic c, f, n, l, z, last;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y); ci = m_flags[3];
    r = m_res; we = 1'b1; c = 0; f = 0; n = 0; l = 0; lat = 1;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x ^ y;
      4'd3: r = ~x;
      4'd4: begin t = ux + uy; r = t[15:0]; f = ((sx + sy) > 32767) || ((sx + sy) < -32768); end
      4'd5: begin t = ux + uy; r = t[15:0]; c = (t > 65535); end
      4'd6: begin
        t = ux + uy + ci; r = t[15:0]; c = (t > 65535);
        f = ((sx + sy + ci) > 32767) || ((sx + sy + ci) < -32768);
      end
      4'd7: begin t = ux + uy + ci; r = t[15:0]; c = (t > 65535); end
      4'd8: begin t = ux - uy; r = t[15:0]; c = (ux < uy); f = ((sx - sy) > 32767) || ((sx - sy) < -32768); end
      4'd9, 4'd10: begin r = 16'h0000; we = 1'b0; n = (sx < sy); l = (ux < uy); end
      4'd11: r = y;
      4'd12, 4'd13: begin
        s = $signed(y[4:0]);
        mag = (s < 0) ? -s : s;
        v = x; last = 1'b0;
        for (int k = 0; k < mag; k++) begin
          if (s > 0) begin last = v[15]; v = v << 1; end
          else begin last = v[0]; v = {(o == 4'd13) ? v[15] : 1'b0, v[15:1]}; end
        end
        r = v; c = last;
        if (mag > 0) lat = mag + 1;
      end
      default: we = 1'b0;
    endcase
    if (o <= 4'd13) begin
      z = (o == 4'd9 || o == 4'd10) ? (x == y) : (r == 16'h0000);
      fl = {z, c, f, n, l};
      m_res = r;
      m_flags = fl;
    end else begin
      fl = m_flags;
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    sb_t e;
    logic [15:0] r;
    logic we;
    logic [4:0] fl;
    int lat, waitn;
    op = o; a = x; b = y; in_valid = 1'b1;
    waitn = 0;
    while (in_ready !== 1'b1 && waitn < 100) begin
      @(negedge clk);
      waitn++;
    end
    if (in_ready !== 1'b1) chk({tag, "_ready_timeout"}, in_ready, 1);
    predict(o, x, y, r, we, fl, lat);
    e.res = r; e.we = we; e.fl = fl; e.cyc = cyc + 1 + lat; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (out_valid === 1'b1) begin
      n_checks++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed result %0h with no pending op", out_result);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, "_result"}, out_result, e.res);
        chk({e.tag, "_we"}, out_result_we, e.we);
        chk({e.tag, "_flags"}, flags, e.fl);
        chk({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    int ready_low;
    int k;
    reset_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    in_valid32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    m_res = '0; m_flags = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_we", out_result_we, 0);
    chk("rst_flags", flags, 0);
    reset_n = 1'b1;
    @(negedge clk);

    issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001);
    issue("addu_wrap", OP_ADDU, 16'hFFFF, 16'h0001);
    issue("addc_cin", OP_ADDC, 16'h0001, 16'h0001);
    issue("cmp", OP_CMP, 16'hFFFF, 16'h0001);
    issue("cmpu", OP_CMPU, 16'hFFFF, 16'h0001);
    issue("cmp_eq", OP_CMP, 16'h1234, 16'h1234);
    issue("and", OP_AND, 16'hF0F0, 16'h3C3C);
    issue("or", OP_OR, 16'hF000, 16'h000F);
    issue("xor", OP_XOR, 16'hAAAA, 16'hAAAA);
    issue("not", OP_NOT, 16'h00FF, 16'h0000);
    issue("mov", OP_MOV, 16'h0000, 16'hBEEF);
    issue("sub_borrow", OP_SUB, 16'h0001, 16'h0002);
    issue("sub_ovf", OP_SUB, 16'h8000, 16'h0001);
    issue("addu_c", OP_ADDU, 16'hFFFF, 16'h0002);
    issue("addcu_fwd", OP_ADDCU, 16'h0000, 16'h0000);
    issue("nop", 4'hE, 16'h1111, 16'h2222);
    issue("add_c0", OP_ADD, 16'hFFFF, 16'h0002);
    drain();

    issue("lsh5", OP_LSH, 16'h0001, 16'h0005);
    in_valid = 1'b0;
    ready_low = 0;
    while (in_ready === 1'b0 && ready_low < 50) begin
      ready_low++;
      @(negedge clk);
    end
    chk("lsh5_ready_low_cycles", ready_low, 5);
    drain();

    issue("ash_r3", OP_ASH, 16'h8000, 16'hFFFD);
    issue("lsh_l1_c", OP_LSH, 16'h8001, 16'h0001);
    issue("lsh_r1_c", OP_LSH, 16'h0003, 16'h001F);
    issue("lsh_zero", OP_LSH, 16'h1234, 16'h0000);
    issue("ash_r16", OP_ASH, 16'h8000, 16'h0010);
    issue("addc_after_sh", OP_ADDC, 16'h0000, 16'h0000);
    issue("lsh_r16", OP_LSH, 16'h8000, 16'h0010);
    issue("ash_l2", OP_ASH, 16'hC001, 16'h0002);
    drain();

    op = OP_LSH; a = 16'h0001; b = 16'h000A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_flags", flags, 0);
    m_res = '0; m_flags = '0;
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    issue("addc_after_rst", OP_ADDC, 16'h0001, 16'h0001);
    drain();

    op32 = OP_ADD; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    @(negedge clk);
    chk("w32_add_valid", out_valid32, 1);
    chk("w32_add_result", out_result32, 64'h8000_0000);
    chk("w32_add_flags", flags32, 5'b00100);
    op32 = OP_LSH; a32 = 32'h1234_5678; b32 = 32'h0000_0020; in_valid32 = 1'b1;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (out_valid32 !== 1'b1 && k < 100);
    chk("w32_lsh_latency", k, 33);
    chk("w32_lsh_result", out_result32, 0);
    chk("w32_lsh_flags", flags32, 5'b10000);
    chk("w32_lsh_we", out_result_we32, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
